pwm_color_decoder: RTL

PWM_COLOR_DECODER -- requirements
Module: pwm_color_decoder

---
 rtl/pwm_color_decoder.sv | 136 +++++++++++++
 1 files changed

// File: rtl/pwm_color_decoder.sv
// Measures the duty of three PWM colour channels over 256-cycle windows and
// classifies the result against a fixed colour table, reporting only stable matches.
module pwm_color_decoder #(
   parameter int TOL         = 2,
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       pwm_R,
   input  logic       pwm_G,
   input  logic       pwm_B,
   output logic [7:0] duty_R,
   output logic [7:0] duty_G,
   output logic [7:0] duty_B,
   output logic       valid,
   output logic [7:0] color_code,
   output logic       color_known
);

   typedef enum logic {DISCARD = 1'b0, MEASURE = 1'b1} state_t;

   // Colour table packed one byte per entry, entry i at bits [8*i +: 8] (bit i of color_code).
   localparam logic [63:0] TBL_R = {8'd255, 8'd128, 8'd0,   8'd0,   8'd0,   8'd255, 8'd255, 8'd255};
   localparam logic [63:0] TBL_G = {8'd255, 8'd0,   8'd0,   8'd0,   8'd255, 8'd255, 8'd102, 8'd0};
   localparam logic [63:0] TBL_B = {8'd255, 8'd128, 8'd128, 8'd255, 8'd0,   8'd0,   8'd0,   8'd0};

   state_t                 state_q, state_d;
   logic [SYNC_STAGES-1:0] sync_r_q, sync_g_q, sync_b_q;
   logic                   s_r, s_g, s_b;
   logic [7:0]             win_q;
   logic                   win_end, publish;
   logic [8:0]             hi_r_q, hi_g_q, hi_b_q;
   logic [8:0]             hi_r_d, hi_g_d, hi_b_d;
   logic [8:0]             sum_r, sum_g, sum_b;
   logic [7:0]             res_r, res_g, res_b;
   logic [7:0]             match;
   logic [7:0]             duty_r_q, duty_g_q, duty_b_q;
   logic [7:0]             color_q, prev_q;
   logic                   valid_q, known_q;

   function automatic logic near(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] diff;
      diff = (a >= b) ? (a - b) : (b - a);
      return (int'(diff) <= TOL);
   endfunction

   assign s_r     = sync_r_q[SYNC_STAGES-1];
   assign s_g     = sync_g_q[SYNC_STAGES-1];
   assign s_b     = sync_b_q[SYNC_STAGES-1];
   assign win_end = (win_q == 8'hFF);
   assign publish = win_end && (state_q == MEASURE);

   // The sample taken at count 255 closes the current window, so the next one starts empty.
   always_comb begin
      sum_r  = hi_r_q + {8'd0, s_r};
      sum_g  = hi_g_q + {8'd0, s_g};
      sum_b  = hi_b_q + {8'd0, s_b};
      res_r  = sum_r[8] ? 8'hFF : sum_r[7:0];
      res_g  = sum_g[8] ? 8'hFF : sum_g[7:0];
      res_b  = sum_b[8] ? 8'hFF : sum_b[7:0];
      hi_r_d = win_end ? 9'd0 : sum_r;
      hi_g_d = win_end ? 9'd0 : sum_g;
      hi_b_d = win_end ? 9'd0 : sum_b;
   end

   // Scan from the top entry down so the lowest matching index is the one kept.
   always_comb begin
      match = 8'd0;
      if ((res_r != 8'd0) || (res_g != 8'd0) || (res_b != 8'd0)) begin
         for (int i = 7; i >= 0; i--) begin
            if (near(res_r, TBL_R[{i[2:0], 3'b000} +: 8]) &&
                near(res_g, TBL_G[{i[2:0], 3'b000} +: 8]) &&
                near(res_b, TBL_B[{i[2:0], 3'b000} +: 8])) begin
               match       = 8'd0;
               match[i[2:0]] = 1'b1;
            end
         end
      end
   end

   always_comb begin
      state_d = state_q;
      if (win_end && (state_q == DISCARD)) begin
         state_d = MEASURE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= DISCARD;
         sync_r_q <= '0;
         sync_g_q <= '0;
         sync_b_q <= '0;
         win_q    <= 8'd0;
         hi_r_q   <= 9'd0;
         hi_g_q   <= 9'd0;
         hi_b_q   <= 9'd0;
         duty_r_q <= 8'd0;
         duty_g_q <= 8'd0;
         duty_b_q <= 8'd0;
         valid_q  <= 1'b0;
         color_q  <= 8'd0;
         known_q  <= 1'b0;
         prev_q   <= 8'd0;
      end else begin
         state_q  <= state_d;
         sync_r_q <= {sync_r_q[SYNC_STAGES-2:0], pwm_R};
         sync_g_q <= {sync_g_q[SYNC_STAGES-2:0], pwm_G};
         sync_b_q <= {sync_b_q[SYNC_STAGES-2:0], pwm_B};
         win_q    <= win_q + 8'd1;
         hi_r_q   <= hi_r_d;
         hi_g_q   <= hi_g_d;
         hi_b_q   <= hi_b_d;
         valid_q  <= publish;
         if (publish) begin
            duty_r_q <= res_r;
            duty_g_q <= res_g;
            duty_b_q <= res_b;
            prev_q   <= match;
            // Only two identical consecutive results are trusted; prev_q of zero means "none".
            if (match == prev_q) begin
               color_q <= match;
               known_q <= (match != 8'd0);
            end
         end
      end
   end

   assign duty_R      = duty_r_q;
   assign duty_G      = duty_g_q;
   assign duty_B      = duty_b_q;
   assign valid       = valid_q;
   assign color_code  = color_q;
   assign color_known = known_q;

endmodule
